// File: rtl/multi_channel_counter_pkg.sv
// Shared types and helpers for the multi-channel counter bank.
//   snap_state_e : snapshot readout FSM states
//   ch_width()   : channel index width for a given channel count (never below 1)
package multi_channel_counter_pkg;

    typedef enum logic [0:0] {
        SNAP_IDLE   = 1'b0,
        SNAP_STREAM = 1'b1
    } snap_state_e;

    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/multi_channel_counter_if.sv
// Snapshot readout stream of the multi-channel counter bank.
//   snap_req   : sink -> counter, request a snapshot
//   snap_ready : sink -> counter, sink accepts the current beat
//   snap_busy  : counter -> sink, stream in progress
//   snap_valid : counter -> sink, beat valid
//   snap_ch    : counter -> sink, channel index of the current beat
//   snap_data  : counter -> sink, captured value of snap_ch
// master = counter bank side, slave = sink side.
interface multi_channel_counter_if #(
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned WIDTH  = 8
) ();
    import multi_channel_counter_pkg::*;

    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic            snap_req;
    logic            snap_ready;
    logic            snap_busy;
    logic            snap_valid;
    logic [CH_W-1:0] snap_ch;
    logic [WIDTH-1:0] snap_data;

    modport master (
        input  snap_req,
        input  snap_ready,
        output snap_busy,
        output snap_valid,
        output snap_ch,
        output snap_data
    );

    modport slave (
        output snap_req,
        output snap_ready,
        input  snap_busy,
        input  snap_valid,
        input  snap_ch,
        input  snap_data
    );

endinterface

// File: rtl/counter_channel.sv
// One up/down counter channel with clear, load and terminal-count pulse.
//   clock, reset : clock and asynchronous active-high reset
//   clr          : synchronous clear (highest priority)
//   load         : load load_value (second priority)
//   en, dir      : count enable, direction (1 = up, 0 = down)
//   count        : registered counter value
//   tc           : registered terminal-count pulse, high with the wrapped/held value
module counter_channel #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (en) begin
            if (dir) begin
                if (count_q == '1) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE != 0) ? count_q : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE != 0) ? count_q : '1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: rtl/multi_channel_counter.sv
// Bank of NUM_CH independent counters with an atomic snapshot readout stream.
//   clock, reset          : clock and asynchronous active-high reset
//   en, clr, dir          : per-channel enable, synchronous clear, direction
//   load_valid/ch/value   : load strobe, target channel, value (out-of-range ch ignored)
//   count                 : packed counters, channel i at [i*WIDTH +: WIDTH]
//   tc                    : per-channel terminal-count pulse
//   snap                  : snapshot request / valid-ready beat stream
module multi_channel_counter
    import multi_channel_counter_pkg::*;
#(
    parameter int unsigned NUM_CH   = 5,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0,
    localparam int unsigned CH_W    = ch_width(NUM_CH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       clr,
    input  logic [NUM_CH-1:0]       dir,
    input  logic                    load_valid,
    input  logic [CH_W-1:0]         load_ch,
    input  logic [WIDTH-1:0]        load_value,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       tc,
    multi_channel_counter_if.master snap
);

    logic [WIDTH-1:0]  cnt_w [NUM_CH];
    logic [NUM_CH-1:0] load_hit;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load_hit[i] = load_valid && (load_ch == CH_W'(i));

        counter_channel #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .clr        (clr[i]),
            .load       (load_hit[i]),
            .load_value (load_value),
            .en         (en[i]),
            .dir        (dir[i]),
            .count      (cnt_w[i]),
            .tc         (tc[i])
        );

        assign count[i*WIDTH +: WIDTH] = cnt_w[i];
    end

    // Snapshot engine
    snap_state_e      state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CH_W-1:0]  ch_next;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] snap_mem_q [NUM_CH];
    logic             capture;

    assign ch_next = ch_q + CH_W'(1);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        data_d  = data_q;
        capture = 1'b0;
        unique case (state_q)
            SNAP_IDLE: begin
                if (snap.snap_req) begin
                    // cnt_w still holds pre-edge values, so the capture is atomic.
                    capture = 1'b1;
                    state_d = SNAP_STREAM;
                    ch_d    = '0;
                    data_d  = cnt_w[0];
                end
            end
            SNAP_STREAM: begin
                if (snap.snap_ready) begin
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        state_d = SNAP_IDLE;
                        ch_d    = '0;
                        data_d  = '0;
                    end else begin
                        ch_d   = ch_next;
                        data_d = snap_mem_q[ch_next];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SNAP_IDLE;
            ch_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_mem_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_mem_q[i] <= cnt_w[i];
            end
        end
    end

    assign snap.snap_busy  = (state_q == SNAP_STREAM);
    assign snap.snap_valid = (state_q == SNAP_STREAM);
    assign snap.snap_ch    = ch_q;
    assign snap.snap_data  = data_q;

endmodule

// File: tb/tb_multi_channel_counter.sv
// Directed self-checking bench for multi_channel_counter: a wrapping instance (dut) and a
// saturating instance (dut_s) share the counter inputs; only dut's snapshot port is exercised.
module tb_multi_channel_counter;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  en, clr, dir;
    logic        load_valid;
    logic [2:0]  load_ch;
    logic [7:0]  load_value;
    logic [39:0] count, count_s;
    logic [4:0]  tc, tc_s;

    int n_checks = 0;
    int n_fail   = 0;

    multi_channel_counter_if #(.NUM_CH(5), .WIDTH(8)) sif ();
    multi_channel_counter_if #(.NUM_CH(5), .WIDTH(8)) sif_s ();

    multi_channel_counter #(.NUM_CH(5), .WIDTH(8), .SATURATE(0)) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .clr        (clr),
        .dir        (dir),
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_value (load_value),
        .count      (count),
        .tc         (tc),
        .snap       (sif)
    );

    multi_channel_counter #(.NUM_CH(5), .WIDTH(8), .SATURATE(1)) dut_s (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .clr        (clr),
        .dir        (dir),
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_value (load_value),
        .count      (count_s),
        .tc         (tc_s),
        .snap       (sif_s)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ch_of(input logic [39:0] c, input int i);
        return c[i*8 +: 8];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        n_checks++;
        if (count !== 40'd0 || tc !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_counts: count=%h tc=%b required 0/0", count, tc);
        end
        n_checks++;
        if (sif.snap_valid !== 1'b0 || sif.snap_busy !== 1'b0 || sif.snap_ch !== 3'd0 ||
            sif.snap_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_snap: valid=%b busy=%b ch=%0d data=%0d required all 0",
                     sif.snap_valid, sif.snap_busy, sif.snap_ch, sif.snap_data);
        end
        reset = 1'b0;
        en    = 5'b11111;
        dir   = 5'b11111;
        repeat (10) step();
        en = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (ch_of(count, i) !== 8'd10) begin
                n_fail++;
                $display("FAIL count10_ch%0d: got %0d required 10", i, ch_of(count, i));
            end
        end
        n_checks++;
        if (tc !== 5'd0) begin
            n_fail++;
            $display("FAIL count10_tc: got %b required 00000", tc);
        end
        // Asynchronous reset in the middle of counting.
        en = 5'b11111;
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (count !== 40'd0 || tc !== 5'd0 || sif.snap_valid !== 1'b0 || sif.snap_busy !== 1'b0)
        begin
            n_fail++;
            $display("FAIL midrun_reset: count=%h tc=%b valid=%b busy=%b required 0",
                     count, tc, sif.snap_valid, sif.snap_busy);
        end
        #2;
        reset = 1'b0;
        en    = 5'b00000;
        step();
        n_checks++;
        if (count !== 40'd0) begin
            n_fail++;
            $display("FAIL post_reset_hold: count=%h required 0", count);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_up [3] = '{8'd255, 8'd0, 8'd0};
        logic       exp_uptc [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] exp_dn [3] = '{8'd0, 8'd255, 8'd255};
        dir        = 5'b11111;
        load_valid = 1'b1;
        load_ch    = 3'd2;
        load_value = 8'd254;
        step();
        load_valid = 1'b0;
        n_checks++;
        if (ch_of(count, 2) !== 8'd254) begin
            n_fail++;
            $display("FAIL load_ch2: got %0d required 254", ch_of(count, 2));
        end
        en = 5'b00100;
        for (int s = 0; s < 3; s++) begin
            if (s == 2) en = 5'b00000;
            step();
            n_checks++;
            if (ch_of(count, 2) !== exp_up[s] || tc[2] !== exp_uptc[s]) begin
                n_fail++;
                $display("FAIL wrap_up_step%0d: count=%0d tc=%b required %0d/%b", s,
                         ch_of(count, 2), tc[2], exp_up[s], exp_uptc[s]);
            end
        end
        load_valid = 1'b1;
        load_ch    = 3'd3;
        load_value = 8'd1;
        step();
        load_valid = 1'b0;
        dir        = 5'b00000;
        en         = 5'b01000;
        for (int s = 0; s < 3; s++) begin
            if (s == 2) en = 5'b00000;
            step();
            n_checks++;
            if (ch_of(count, 3) !== exp_dn[s] || tc[3] !== exp_uptc[s]) begin
                n_fail++;
                $display("FAIL wrap_dn_step%0d: count=%0d tc=%b required %0d/%b", s,
                         ch_of(count, 3), tc[3], exp_dn[s], exp_uptc[s]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_s [5]  = '{8'd254, 8'd255, 8'd255, 8'd255, 8'd255};
        logic       exp_st [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp_w [5]  = '{8'd254, 8'd255, 8'd0, 8'd1, 8'd2};
        logic       exp_wt [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        dir        = 5'b11111;
        load_valid = 1'b1;
        load_ch    = 3'd0;
        load_value = 8'd253;
        step();
        load_valid = 1'b0;
        en         = 5'b00001;
        for (int s = 0; s < 5; s++) begin
            step();
            n_checks++;
            if (ch_of(count_s, 0) !== exp_s[s] || tc_s[0] !== exp_st[s]) begin
                n_fail++;
                $display("FAIL sat_step%0d: count=%0d tc=%b required %0d/%b", s,
                         ch_of(count_s, 0), tc_s[0], exp_s[s], exp_st[s]);
            end
            n_checks++;
            if (ch_of(count, 0) !== exp_w[s] || tc[0] !== exp_wt[s]) begin
                n_fail++;
                $display("FAIL wrapmode_step%0d: count=%0d tc=%b required %0d/%b", s,
                         ch_of(count, 0), tc[0], exp_w[s], exp_wt[s]);
            end
        end
        en = 5'b00000;
    endtask

    task automatic test_priority();
        clr        = 5'b00010;
        en         = 5'b00010;
        dir        = 5'b11111;
        load_valid = 1'b1;
        load_ch    = 3'd1;
        load_value = 8'd77;
        step();
        n_checks++;
        if (ch_of(count, 1) !== 8'd0 || tc[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_clr: count=%0d tc=%b required 0/0", ch_of(count, 1), tc[1]);
        end
        clr = 5'b00000;
        en  = 5'b00000;
        step();
        n_checks++;
        if (ch_of(count, 1) !== 8'd77) begin
            n_fail++;
            $display("FAIL prio_load: got %0d required 77", ch_of(count, 1));
        end
        load_ch    = 3'd7;
        load_value = 8'd33;
        step();
        load_valid = 1'b0;
        // Channels hold {0, 255, 0, 77, 2} from ch4 down to ch0.
        n_checks++;
        if (count !== 40'h00_ff_00_4d_02) begin
            n_fail++;
            $display("FAIL load_out_of_range: got %h required 00ff004d02", count);
        end
    endtask

    task automatic test_snapshot();
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_ch    = 3'(i);
            load_value = 8'(5 + i);
            step();
        end
        load_valid     = 1'b0;
        en             = 5'b11111;
        dir            = 5'b11111;
        sif.snap_req   = 1'b1;
        sif.snap_ready = 1'b1;
        step();
        sif.snap_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (sif.snap_valid !== 1'b1 || sif.snap_busy !== 1'b1 || sif.snap_ch !== 3'(k) ||
                sif.snap_data !== 8'(5 + k)) begin
                n_fail++;
                $display("FAIL snap_beat%0d: valid=%b busy=%b ch=%0d data=%0d required 1/1/%0d/%0d",
                         k, sif.snap_valid, sif.snap_busy, sif.snap_ch, sif.snap_data, k, 5 + k);
            end
            step();
        end
        en = 5'b00000;
        n_checks++;
        if (sif.snap_valid !== 1'b0 || sif.snap_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL snap_end: valid=%b busy=%b required 0/0", sif.snap_valid, sif.snap_busy);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (ch_of(count, i) !== 8'(11 + i)) begin
                n_fail++;
                $display("FAIL live_count_ch%0d: got %0d required %0d", i, ch_of(count, i), 11 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int k   = 0;
        int cyc = 0;
        sif.snap_req   = 1'b1;
        sif.snap_ready = 1'b0;
        step();
        sif.snap_req = 1'b0;
        while (k < 5 && cyc < 40) begin
            sif.snap_ready = (cyc % 2) == 1;
            // A request mid-stream and one in the last-accept cycle must both be dropped.
            sif.snap_req   = (cyc == 4) || (k == 4 && sif.snap_ready);
            n_checks++;
            if (sif.snap_valid !== 1'b1 || sif.snap_ch !== 3'(k) || sif.snap_data !== 8'(11 + k))
            begin
                n_fail++;
                $display("FAIL bp_cyc%0d: valid=%b ch=%0d data=%0d required 1/%0d/%0d", cyc,
                         sif.snap_valid, sif.snap_ch, sif.snap_data, k, 11 + k);
            end
            step();
            if (sif.snap_ready) k++;
            cyc++;
        end
        sif.snap_req   = 1'b0;
        sif.snap_ready = 1'b0;
        n_checks++;
        if (k != 5) begin
            n_fail++;
            $display("FAIL bp_beats: accepted %0d required 5 within 40 cycles", k);
        end
        n_checks++;
        if (sif.snap_valid !== 1'b0 || sif.snap_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: valid=%b busy=%b required 0/0", sif.snap_valid, sif.snap_busy);
        end
        step();
        n_checks++;
        if (sif.snap_valid !== 1'b0 || sif.snap_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_req_not_queued: valid=%b busy=%b required 0/0",
                     sif.snap_valid, sif.snap_busy);
        end
    endtask

    task automatic test_reset_stream();
        sif.snap_req   = 1'b1;
        sif.snap_ready = 1'b0;
        step();
        sif.snap_req   = 1'b0;
        sif.snap_ready = 1'b1;
        step();
        n_checks++;
        if (sif.snap_ch !== 3'd1 || sif.snap_data !== 8'd12) begin
            n_fail++;
            $display("FAIL rs_beat1: ch=%0d data=%0d required 1/12", sif.snap_ch, sif.snap_data);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (sif.snap_valid !== 1'b0 || sif.snap_busy !== 1'b0 || sif.snap_ch !== 3'd0 ||
            sif.snap_data !== 8'd0 || count !== 40'd0) begin
            n_fail++;
            $display("FAIL rs_reset: valid=%b busy=%b ch=%0d data=%0d count=%h required all 0",
                     sif.snap_valid, sif.snap_busy, sif.snap_ch, sif.snap_data, count);
        end
        #2;
        reset          = 1'b0;
        sif.snap_ready = 1'b0;
        step();
        n_checks++;
        if (sif.snap_valid !== 1'b0 || sif.snap_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rs_idle: valid=%b busy=%b required 0/0", sif.snap_valid, sif.snap_busy);
        end
    endtask

    initial begin
        reset            = 1'b0;
        en               = '0;
        clr              = '0;
        dir              = '0;
        load_valid       = 1'b0;
        load_ch          = '0;
        load_value       = '0;
        sif.snap_req     = 1'b0;
        sif.snap_ready   = 1'b0;
        sif_s.snap_req   = 1'b0;
        sif_s.snap_ready = 1'b0;
        #1;
        test_reset();
        test_wrap();
        test_saturate();
        test_priority();
        test_snapshot();
        test_backpressure();
        test_reset_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_counter.md
Name: multi_channel_counter

Overview:
- Parametrised bank of NUM_CH independent counters sharing one clock and one reset.
- Each channel has its own enable, synchronous clear, load, direction and terminal-count pulse.
- Wrap or saturate mode is selected by parameter.
- A snapshot engine atomically captures all counters and streams them out one channel per beat over a valid/ready handshake, for testbench and debug readout.

Parameters:
- NUM_CH, 5, number of counter channels (>=1).
- WIDTH, 8, counter width in bits (>=2).
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.
- CH_W, $clog2(NUM_CH) min 1, channel index width (derived, localparam).

Ports:
- clock  in  1  sole clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  NUM_CH  per-channel count enable.
- clr  in  NUM_CH  per-channel synchronous clear.
- dir  in  NUM_CH  per-channel direction, 1 = up, 0 = down.
- load_valid  in  1  load strobe.
- load_ch  in  CH_W  channel to load.
- load_value  in  WIDTH  value to load.
- count  out  NUM_CH*WIDTH  registered counters, channel i at [i*WIDTH +: WIDTH].
- tc  out  NUM_CH  one-cycle terminal-count pulse per channel.
- snap_req  in  1  request snapshot.
- snap_busy  out  1  snapshot stream in progress.
- snap_valid  out  1  snapshot beat valid.
- snap_ready  in  1  sink accepts beat.
- snap_ch  out  CH_W  channel index of current beat.
- snap_data  out  WIDTH  snapshot value of snap_ch.

Behaviour:

Reset
- Asserting reset at any time, including mid-stream, immediately sets count, tc, snap_valid, snap_busy, snap_ch and snap_data to 0 and returns the FSM to IDLE.
- Deassertion takes effect on the next posedge.

Per-channel priority (evaluated each posedge)
1. clr[i]: count := 0, tc := 0.
2. Load (load_valid && load_ch == i): count := load_value, tc := 0.
3. en[i]:
   - Up: at all-ones, wrap to 0 (SATURATE=0) or hold (SATURATE=1); tc[i] := 1 in either case. Otherwise count + 1, tc := 0.
   - Down: at 0, wrap to all-ones or hold; tc[i] := 1. Otherwise count - 1, tc := 0.
4. None of the above: count holds, tc := 0.

Counter and load rules
- tc is registered alongside count, so it is high in the same cycle count shows the wrapped or held value.
- In saturate mode, tc pulses on every enabled cycle spent at the limit.
- load_ch >= NUM_CH: load is ignored.
- Arithmetic is modulo 2^WIDTH; no overflow outputs beyond tc.
- Channels are fully independent; simultaneous events on different channels all take effect in the same cycle.

Snapshot FSM (states IDLE, STREAM)
- IDLE, snap_req=1:
  - Capture all count values as they are before this edge's updates, i.e. the values visible on count in the request cycle.
  - Next cycle: STREAM, snap_busy=1, snap_valid=1, snap_ch=0, snap_data=snapshot[0].
- STREAM, snap_valid && snap_ready:
  - If snap_ch < NUM_CH-1, increment snap_ch and present the next snapshot word.
  - If snap_ch == NUM_CH-1, go to IDLE with snap_valid=0, snap_busy=0.
- STREAM, snap_ready=0: snap_ch and snap_data hold stable, snap_valid stays high.
- snap_req while STREAM: ignored, not queued.
- snap_req in the cycle the last beat is accepted: ignored; a new request is only sampled in IDLE.
- Counting continues normally during STREAM; the snapshot is unaffected by live updates.
- Throughput: one beat per cycle under continuous snap_ready. A full dump takes NUM_CH cycles after the 1-cycle request latency.
- NUM_CH=1: STREAM lasts until the single beat is accepted.

Decomposition:
- Package multi_channel_counter_pkg holds:
  - the FSM state enum snap_state_e {SNAP_IDLE, SNAP_STREAM};
  - a function returning the channel index width for a given count.
- Sub-module counter_channel (parameters WIDTH, SATURATE; ports clock, reset, clr, load, load_value, en, dir, count, tc).
  - Instantiated NUM_CH times via generate.
  - The top level owns the load decode and the snapshot FSM/registers.

Test Plan:
1. Reset, then en=all-ones and dir=all-ones for 10 cycles -> every channel count=10, tc all 0; assert reset mid-run -> all outputs 0 immediately.
2. Wrap:
   - SATURATE=0: load ch2 with 254, up-count 2 cycles -> 255, then 0 with tc[2]=1 for exactly one cycle.
   - Load ch3 with 1, down-count -> 0, then 255 with tc[3]=1.
3. Saturate, SATURATE=1: ch0 loaded 253, up 5 cycles -> 254, 255, 255, 255, 255; tc[0] high on the last 3 of those cycles.
4. Priority: same cycle clr[1]=1, load_valid with load_ch=1 and load_value=77, en[1]=1 -> count1=0. Next cycle load only -> 77. load_ch=7 with NUM_CH=5 -> no channel changes.
5. Snapshot:
   - Counts {5,6,7,8,9}, snap_req one cycle while counting continues, snap_ready=1 -> beats ch0..4 with data 5,6,7,8,9 on 5 consecutive cycles; snap_busy drops after the last beat.
6. Backpressure:
   - snap_ready toggled 0/1 -> data and ch stable while stalled, no beat lost or duplicated.
   - snap_req during STREAM -> ignored.
   - Reset during STREAM -> snap_valid=0 and state IDLE.
